// File: rtl/vga_cam_pkg.sv
// Shared camera/VGA definitions: image geometry defaults, pixel format,
// capture FSM states and the colour-bar test pattern helpers.
package vga_cam_pkg;

  localparam int IMG_W_DEF  = 320;
  localparam int IMG_H_DEF  = 240;
  localparam int ADDR_W_DEF = 17;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic {
    S_WAIT   = 1'b0,
    S_ACTIVE = 1'b1
  } cap_state_t;

  localparam rgb444_t BAR_WHITE   = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb444_t BAR_YELLOW  = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb444_t BAR_CYAN    = '{r: 4'h0, g: 4'hF, b: 4'hF};
  localparam rgb444_t BAR_GREEN   = '{r: 4'h0, g: 4'hF, b: 4'h0};
  localparam rgb444_t BAR_MAGENTA = '{r: 4'hF, g: 4'h0, b: 4'hF};
  localparam rgb444_t BAR_RED     = '{r: 4'hF, g: 4'h0, b: 4'h0};
  localparam rgb444_t BAR_BLUE    = '{r: 4'h0, g: 4'h0, b: 4'hF};
  localparam rgb444_t BAR_BLACK   = '{r: 4'h0, g: 4'h0, b: 4'h0};

  // Bar index 0..7 for a column; bars are img_w/8 pixels wide.
  function automatic logic [2:0] bar_index(input logic [8:0] x, input int img_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x) >= (k * img_w) / 8) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic rgb444_t bar_colour(input logic [2:0] idx);
    rgb444_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ov7670_frame_capture_if.sv
// Camera bus plus frame-buffer write port of the OV7670 capture stage.
// The camera/controller side is the master, the capture block the slave.
// test_sel exists only when OV7670_TEST_PATTERN_EN is defined.
interface ov7670_frame_capture_if #(
  parameter int ADDR_W = 17
);
  logic              cap_en;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_data;
`ifdef OV7670_TEST_PATTERN_EN
  logic              test_sel;
`endif
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [11:0]       wData;
  logic              busy;
  logic              frame_done;
  logic              err_ovf;

`ifdef OV7670_TEST_PATTERN_EN
  modport master (
    output cap_en, vsync, href, cam_data, test_sel,
    input  we, wAddr, wData, busy, frame_done, err_ovf
  );
  modport slave (
    input  cap_en, vsync, href, cam_data, test_sel,
    output we, wAddr, wData, busy, frame_done, err_ovf
  );
`else
  modport master (
    output cap_en, vsync, href, cam_data,
    input  we, wAddr, wData, busy, frame_done, err_ovf
  );
  modport slave (
    input  cap_en, vsync, href, cam_data,
    output we, wAddr, wData, busy, frame_done, err_ovf
  );
`endif
endinterface

// File: rtl/rgb565_to_rgb444.sv
// Packs an RGB565 byte pair (d0 = first byte, d1 = second) into RGB444
// by keeping the top four bits of each component.
module rgb565_to_rgb444
  import vga_cam_pkg::*;
(
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  output rgb444_t    pix
);

  logic unused_bits;

  // Truncate each 565 component to its four most significant bits.
  always_comb begin
    pix.r = d0[7:4];
    pix.g = {d0[2:0], d1[7]};
    pix.b = d1[4:1];
  end

  assign unused_bits = ^{d0[3], d1[6:5], d1[0]};

endmodule

// File: rtl/ov7670_frame_capture.sv
// OV7670 whole-frame capture: samples the camera byte bus, packs RGB565 to
// RGB444 and writes pixels at y*IMG_W + x. Optional macro
// OV7670_TEST_PATTERN_EN adds test_sel to replace pixels with colour bars.
//
// state    | meaning
// S_WAIT   | idle between frames, waiting for VSYNC fall with cap_en=1
// S_ACTIVE | capturing a frame until VSYNC rises
module ov7670_frame_capture
  import vga_cam_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                  clk,
  input logic                  reset,
  ov7670_frame_capture_if.slave bus
);

  localparam logic [8:0]        W9     = 9'(IMG_W);
  localparam logic [8:0]        H9     = 9'(IMG_H);
  localparam logic [ADDR_W-1:0] W_ADDR = ADDR_W'(IMG_W);

  cap_state_t        state_q, state_d;
  logic              vsync_d, href_d, phase;
  logic [7:0]        d0_q;
  logic [8:0]        x_q, y_q;
  logic [ADDR_W-1:0] line_base_q;
  logic              we_q, done_q, ovf_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [11:0]       wdata_q;

  logic    frame_start, vsync_rise, href_fall, pix_valid, in_range;
  logic    restart, finish;
  rgb444_t cam_pix, pix_word;

  assign frame_start = vsync_d & ~bus.vsync;
  assign vsync_rise  = ~vsync_d & bus.vsync;
  assign href_fall   = href_d & ~bus.href;
  assign pix_valid   = bus.href & phase;
  assign in_range    = (x_q < W9) && (y_q < H9);

  rgb565_to_rgb444 u_pack (
    .d0  (d0_q),
    .d1  (bus.cam_data),
    .pix (cam_pix)
  );

  // Pixel value source: camera data, or colour bars when selected.
  always_comb begin
`ifdef OV7670_TEST_PATTERN_EN
    pix_word = bus.test_sel ? bar_colour(bar_index(x_q, IMG_W)) : cam_pix;
`else
    pix_word = cam_pix;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_WAIT;
    else       state_q <= state_d;
  end

  // Next state; a VSYNC fall while active is a glitch and just restarts.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (frame_start && bus.cap_en) begin
          state_d = S_ACTIVE;
          restart = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (frame_start) begin
          restart = 1'b1;
        end else if (vsync_rise) begin
          state_d = S_WAIT;
          finish  = 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Edge history, byte phase, pixel counters and registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      phase       <= 1'b0;
      d0_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vsync_d <= bus.vsync;
      href_d  <= bus.href;
      phase   <= bus.href ? ~phase : 1'b0;
      if (bus.href && !phase) d0_q <= bus.cam_data;
      we_q   <= 1'b0;
      done_q <= finish;
      if (restart) begin
        x_q         <= '0;
        y_q         <= '0;
        line_base_q <= '0;
        ovf_q       <= 1'b0;
      end else if (state_q == S_ACTIVE) begin
        if (pix_valid) begin
          if (in_range) begin
            we_q    <= 1'b1;
            waddr_q <= line_base_q + ADDR_W'(x_q);
            wdata_q <= pix_word;
            x_q     <= x_q + 9'd1;
          end else begin
            ovf_q <= 1'b1;
          end
        end else if (href_fall && (x_q != 9'd0)) begin
          x_q         <= '0;
          y_q         <= y_q + 9'd1;
          line_base_q <= line_base_q + W_ADDR;
        end
      end
    end
  end

  assign bus.we         = we_q;
  assign bus.wAddr      = waddr_q;
  assign bus.wData      = wdata_q;
  assign bus.busy       = (state_q == S_ACTIVE);
  assign bus.frame_done = done_q;
  assign bus.err_ovf    = ovf_q;

endmodule
